pipe_hazard_unit: RTL and testbench

- Parametrised hazard-detection and forwarding unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps a shift-register scoreboard of the in-flight writers in EX, MEM and WB.
- Produces the load-use stall, forwards EX/MEM/WB results to the ID-stage operands, and inserts bubbles on stall and flush.
- Sits between Registers/Control and the ALU; replaces the direct rsData/rtData paths to the ALU.

---
 rtl/pipe_hazard_unit.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding for the 5-stage pipeline.
// A three-slot scoreboard (EX, MEM, WB) shadows the in-flight writers. From it
// the unit derives the load-use stall and the per-operand forwarding selects,
// and it counts stall and flush cycles in saturating counters.
module pipe_hazard_unit #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_dest,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          flush,
    input  logic [DW-1:0] rf_rs_data,
    input  logic [DW-1:0] rf_rt_data,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] mem_result,
    input  logic [DW-1:0] wb_result,
    output logic          stall,
    output logic [1:0]    fwd_sel_rs,
    output logic [1:0]    fwd_sel_rt,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [CW-1:0] stall_count,
    output logic [CW-1:0] flush_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // scoreboard slots
    logic          ex_valid_q,  ex_valid_d;
    logic [AW-1:0] ex_dest_q,   ex_dest_d;
    logic          ex_rw_q,     ex_rw_d;
    logic          ex_mr_q,     ex_mr_d;
    logic          mem_valid_q, mem_valid_d;
    logic [AW-1:0] mem_dest_q,  mem_dest_d;
    logic          mem_rw_q,    mem_rw_d;
    logic          mem_mr_q,    mem_mr_d;
    logic          wb_valid_q,  wb_valid_d;
    logic [AW-1:0] wb_dest_q,   wb_dest_d;
    logic          wb_rw_q,     wb_rw_d;
    logic          wb_mr_q,     wb_mr_d;

    logic [CW-1:0] stall_count_q, stall_count_d;
    logic [CW-1:0] flush_count_q, flush_count_d;

    logic ex_writer, mem_writer, wb_writer;
    logic ex_fwd_ok;
    logic hazard;

    // Pick the youngest slot that can supply a value for one operand.
    // A load in EX is skipped: its data does not exist yet and the stall covers it.
    function automatic logic [1:0] pick_src(
        input logic          use_op,
        input logic [AW-1:0] op,
        input logic          ex_ok,
        input logic [AW-1:0] ex_d,
        input logic          mem_ok,
        input logic [AW-1:0] mem_d,
        input logic          wb_ok,
        input logic [AW-1:0] wb_d
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_op) begin
            if (ex_ok && (ex_d == op))
                sel = SEL_EX;
            else if (mem_ok && (mem_d == op))
                sel = SEL_MEM;
            else if (wb_ok && (wb_d == op))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    // Hazard detection, forwarding selects and operand muxes.
    always_comb begin
        ex_writer  = ex_valid_q  && ex_rw_q  && (ex_dest_q  != '0);
        mem_writer = mem_valid_q && mem_rw_q && (mem_dest_q != '0);
        wb_writer  = wb_valid_q  && wb_rw_q  && (wb_dest_q  != '0);
        ex_fwd_ok  = ex_writer && !ex_mr_q;

        hazard = id_valid && ex_writer && ex_mr_q &&
                 ((id_use_rs && (id_rs == ex_dest_q)) ||
                  (id_use_rt && (id_rt == ex_dest_q)));
        stall  = hazard && !flush;

        fwd_sel_rs = pick_src(id_use_rs, id_rs, ex_fwd_ok, ex_dest_q,
                              mem_writer, mem_dest_q, wb_writer, wb_dest_q);
        fwd_sel_rt = pick_src(id_use_rt, id_rt, ex_fwd_ok, ex_dest_q,
                              mem_writer, mem_dest_q, wb_writer, wb_dest_q);

        case (fwd_sel_rs)
            SEL_EX:  rs_data = ex_result;
            SEL_MEM: rs_data = mem_result;
            SEL_WB:  rs_data = wb_result;
            default: rs_data = rf_rs_data;
        endcase

        case (fwd_sel_rt)
            SEL_EX:  rt_data = ex_result;
            SEL_MEM: rt_data = mem_result;
            SEL_WB:  rt_data = wb_result;
            default: rt_data = rf_rt_data;
        endcase
    end

    // Next scoreboard contents and saturating counter values.
    always_comb begin
        wb_valid_d  = mem_valid_q;
        wb_dest_d   = mem_dest_q;
        wb_rw_d     = mem_rw_q;
        wb_mr_d     = mem_mr_q;
        mem_valid_d = ex_valid_q;
        mem_dest_d  = ex_dest_q;
        mem_rw_d    = ex_rw_q;
        mem_mr_d    = ex_mr_q;

        if (stall || flush) begin
            ex_valid_d = 1'b0;
            ex_dest_d  = '0;
            ex_rw_d    = 1'b0;
            ex_mr_d    = 1'b0;
        end else begin
            ex_valid_d = id_valid;
            ex_dest_d  = id_dest;
            ex_rw_d    = id_reg_write;
            ex_mr_d    = id_mem_read;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != CNT_MAX))
            stall_count_d = stall_count_q + CNT_ONE;

        flush_count_d = flush_count_q;
        if (flush && (flush_count_q != CNT_MAX))
            flush_count_d = flush_count_q + CNT_ONE;
    end

    // Scoreboard and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_dest_q     <= '0;
            ex_rw_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_dest_q    <= '0;
            mem_rw_q      <= 1'b0;
            mem_mr_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_dest_q     <= '0;
            wb_rw_q       <= 1'b0;
            wb_mr_q       <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_dest_q     <= ex_dest_d;
            ex_rw_q       <= ex_rw_d;
            ex_mr_q       <= ex_mr_d;
            mem_valid_q   <= mem_valid_d;
            mem_dest_q    <= mem_dest_d;
            mem_rw_q      <= mem_rw_d;
            mem_mr_q      <= mem_mr_d;
            wb_valid_q    <= wb_valid_d;
            wb_dest_q     <= wb_dest_d;
            wb_rw_q       <= wb_rw_d;
            wb_mr_q       <= wb_mr_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a pipeline-level reference model checked on every
// cycle, directed instruction sequences with literal expectations, then random
// traffic. A second instance with 4-bit counters exercises saturation quickly.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read, flush;
    logic [31:0] rf_rs_data, rf_rt_data, ex_result, mem_result, wb_result;

    logic        stall, stall_s;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt, fwd_sel_rs_s, fwd_sel_rt_s;
    logic [31:0] rs_data, rt_data, rs_data_s, rt_data_s;
    logic [15:0] stall_count, flush_count;
    logic [3:0]  stall_count_s, flush_count_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.AW(5), .DW(32), .CW(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_result(ex_result),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall),
        .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .rs_data(rs_data),
        .rt_data(rt_data), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_hazard_unit #(.AW(5), .DW(32), .CW(4)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_result(ex_result),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall_s),
        .fwd_sel_rs(fwd_sel_rs_s), .fwd_sel_rt(fwd_sel_rt_s), .rs_data(rs_data_s),
        .rt_data(rt_data_s), .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    // Reference model: the instructions occupying EX, MEM and WB.
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       rw;
        bit       mr;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int    m_sc, m_fc;

    function automatic bit writes_reg(slot_t s);
        return s.v && s.rw && (s.d != 5'd0);
    endfunction

    function automatic bit model_stall();
        bit uses;
        uses = (id_use_rs && id_rs == m_ex.d) || (id_use_rt && id_rt == m_ex.d);
        return id_valid && writes_reg(m_ex) && m_ex.mr && uses && !flush;
    endfunction

    function automatic bit [1:0] model_sel(bit use_op, bit [4:0] r);
        if (!use_op) return 2'd0;
        if (writes_reg(m_ex) && !m_ex.mr && m_ex.d == r) return 2'd1;
        if (writes_reg(m_mem) && m_mem.d == r) return 2'd2;
        if (writes_reg(m_wb) && m_wb.d == r) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit [31:0] model_data(bit [1:0] sel, bit [31:0] rf);
        case (sel)
            2'd1:    return ex_result;
            2'd2:    return mem_result;
            2'd3:    return wb_result;
            default: return rf;
        endcase
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare of both instances against the model.
    task automatic check_all();
        bit [1:0] es_rs, es_rt;
        bit       es;
        es    = model_stall();
        es_rs = model_sel(id_use_rs, id_rs);
        es_rt = model_sel(id_use_rt, id_rt);
        chk("stall", {31'd0, stall}, {31'd0, es});
        chk("fwd_sel_rs", {30'd0, fwd_sel_rs}, {30'd0, es_rs});
        chk("fwd_sel_rt", {30'd0, fwd_sel_rt}, {30'd0, es_rt});
        chk("rs_data", rs_data, model_data(es_rs, rf_rs_data));
        chk("rt_data", rt_data, model_data(es_rt, rf_rt_data));
        chk("stall_count", {16'd0, stall_count}, sat(m_sc, 65535));
        chk("flush_count", {16'd0, flush_count}, sat(m_fc, 65535));
        chk("stall_s", {31'd0, stall_s}, {31'd0, es});
        chk("rs_data_s", rs_data_s, model_data(es_rs, rf_rs_data));
        chk("stall_count_s", {28'd0, stall_count_s}, sat(m_sc, 15));
        chk("flush_count_s", {28'd0, flush_count_s}, sat(m_fc, 15));
    endtask

    task automatic update_model();
        bit es;
        es = model_stall();
        if (reset) begin
            m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0}; m_wb = '{0, 0, 0, 0};
            m_sc = 0; m_fc = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (es || flush) m_ex = '{0, 0, 0, 0};
            else m_ex = '{id_valid, id_dest, id_reg_write, id_mem_read};
            if (es) m_sc = sat(m_sc + 1, 65535);
            if (flush) m_fc = sat(m_fc + 1, 65535);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic set_id(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                          bit [4:0] dst, bit rw, bit mr, bit fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dest = dst; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rf_rs_data = 32'hA0A0_0001; rf_rt_data = 32'hB0B0_0002;
        ex_result = 32'h0; mem_result = 32'h0; wb_result = 32'h0;
        m_sc = 0; m_fc = 0;
        @(posedge clk); #1;
        update_model();
        step();
        reset = 1'b0;

        // Outputs right after reset
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd9, 1, 0, 0);
        settle();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
        chk("rst_rs_data", rs_data, 32'hA0A0_0001);
        chk("rst_rt_data", rt_data, 32'hB0B0_0002);
        chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
        adv();

        // ADD $3 then SUB reading $3
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0, 0); step();
        set_id(1, 5'd3, 0, 1, 0, 5'd8, 1, 0, 0); ex_result = 32'h11;
        settle();
        chk("exfwd_sel", {30'd0, fwd_sel_rs}, 32'd1);
        chk("exfwd_data", rs_data, 32'h11);
        chk("exfwd_stall", {31'd0, stall}, 32'd0);
        adv();

        // LW $4 then ADD reading $4 as rt
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); step();
        set_id(1, 5'd1, 5'd4, 0, 1, 5'd9, 1, 0, 0); mem_result = 32'hDEAD;
        settle();
        chk("lu_stall1", {31'd0, stall}, 32'd1);
        adv();
        settle();
        chk("lu_stall2", {31'd0, stall}, 32'd0);
        chk("lu_sel_rt", {30'd0, fwd_sel_rt}, 32'd2);
        chk("lu_rt_data", rt_data, 32'hDEAD);
        chk("lu_stall_count", {16'd0, stall_count}, 32'd1);
        adv();

        // Loads to $0 fill the pipe; reading $0 must never forward or stall
        do_reset();
        repeat (3) begin set_id(1, 0, 0, 0, 0, 5'd0, 1, 1, 0); step(); end
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0);
        settle();
        chk("r0_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
        chk("r0_sel_rt", {30'd0, fwd_sel_rt}, 32'd0);
        chk("r0_stall", {31'd0, stall}, 32'd0);
        adv();

        // $5 written in EX and WB: youngest wins
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 5'd5, 0, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 0, 0); step();
        set_id(1, 5'd5, 0, 1, 0, 5'd2, 1, 0, 0); ex_result = 32'd1; wb_result = 32'd2;
        settle();
        chk("young_sel", {30'd0, fwd_sel_rs}, 32'd1);
        chk("young_data", rs_data, 32'd1);
        adv();

        // Load-use together with flush; the killed instruction writes $7
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); step();
        set_id(1, 5'd4, 0, 1, 0, 5'd7, 1, 0, 1);
        settle();
        chk("fl_stall", {31'd0, stall}, 32'd0);
        adv();
        set_id(1, 5'd7, 5'd4, 1, 1, 5'd10, 1, 0, 0);
        settle();
        chk("fl_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
        chk("fl_sel_rt", {30'd0, fwd_sel_rt}, 32'd2);
        chk("fl_count", {16'd0, flush_count}, 32'd1);
        adv();

        // 20 load-use stalls: 4-bit counter pins at 15, 16-bit reaches 20
        do_reset();
        repeat (20) begin
            set_id(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); step();
            set_id(1, 5'd4, 0, 1, 0, 5'd9, 1, 0, 0); step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("sat_count16", {16'd0, stall_count}, 32'd20);
        chk("sat_count4", {28'd0, stall_count_s}, 32'd15);
        adv();

        // Reset asserted during a stall
        set_id(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); step();
        set_id(1, 5'd4, 5'd4, 1, 1, 5'd9, 1, 0, 0); reset = 1'b1;
        settle();
        chk("rs_mid_stall", {31'd0, stall}, 32'd1);
        adv();
        reset = 1'b0;
        settle();
        chk("rs_after_stall", {31'd0, stall}, 32'd0);
        chk("rs_after_sel", {30'd0, fwd_sel_rs}, 32'd0);
        chk("rs_after_count", {16'd0, stall_count}, 32'd0);
        adv();

        // Random traffic over a narrow register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            set_id($urandom_range(7) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                   $urandom_range(1) == 1, $urandom_range(1) == 1, 5'($urandom_range(3)),
                   $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0);
            rf_rs_data = $urandom; rf_rt_data = $urandom;
            ex_result = $urandom; mem_result = $urandom; wb_result = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
